bist_scan_controller: RTL and testbench
=======================================

Name: bist_scan_controller

Overview:
- Upstream sequencer for the per-scan BIST path.
- Generates pseudo-random scan-in patterns with a 16-bit LFSR and sequences shift and capture for the circuit under test.
- Drives the signature compactor's reset and enable inputs so that only valid unloaded responses are accumulated.
- At the end of a run, samples the compactor's pass/fail compare and holds the verdict until the next run.

Parameters:
- CHAIN_LENGTH, 32: scan chain length in flops (≥2); shift cycles per pattern.
- NUM_PATTERNS, 100: number of patterns applied per run (≥1).
- LFSR_SEED, 16'hACE1: LFSR load value; must be non-zero.

Ports:
- clock  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state while low.
- start  input  1  sampled in IDLE or DONE; a high sample begins a run.
- abort  input  1  synchronous; when high in any non-IDLE state, the next state is IDLE.
- pass_nfail_in  input  1  golden-compare result from the signature compactor.
- scan_in  output  1  serial pattern bit into the CUT scan chain.
- scan_enable  output  1  high = shift mode; low = functional capture.
- test_mode  output  1  high whenever state is not IDLE and not DONE.
- misr_reset  output  1  active-high synchronous clear for the compactor.
- misr_enable  output  1  compactor accumulate strobe.
- busy  output  1  identical to test_mode.
- done  output  1  high in DONE.
- pass  output  1  latched verdict; meaningful only while done is high.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; lfsr=LFSR_SEED; bit_cnt=0; pat_cnt=0.
  - Every output reads 0, including scan_in, pass and done.
- Outputs are Moore-decoded from registered state and counters; no input-to-output combinational paths.
- LFSR (Fibonacci, x^16+x^14+x^13+x^11+1):
  - fb = l[0]^l[2]^l[3]^l[5]; next = {fb, l[15:1]}.
  - scan_in = l[0] in SHIFT, 0 in every other state.
  - Advances only on SHIFT cycles; holds otherwise.
  - From the default seed, the first scan_in bits are 1, 0 (0xACE1 → 0x5670).
- IDLE: all outputs 0. start=1 → INIT.
- INIT (1 cycle):
  - misr_reset=1, test_mode=1.
  - lfsr reloads LFSR_SEED; bit_cnt=0; pat_cnt=0.
  - Next state: SHIFT.
- SHIFT (CHAIN_LENGTH cycles):
  - scan_enable=1.
  - misr_enable=1 iff pat_cnt≥1, because unloading of pattern 0 carries no valid response.
  - bit_cnt increments each cycle; at bit_cnt==CHAIN_LENGTH-1, bit_cnt clears and next state is CAPTURE.
- CAPTURE (1 cycle):
  - scan_enable=0, misr_enable=0.
  - pat_cnt increments.
  - If the incremented pat_cnt==NUM_PATTERNS, next state is FLUSH; otherwise SHIFT.
- FLUSH (CHAIN_LENGTH cycles):
  - scan_enable=1, misr_enable=1, scan_in=0; unloads the final response.
  - bit_cnt counts as in SHIFT, then next state is EVAL.
- EVAL (1 cycle):
  - All enables 0; lets the last compactor update settle.
  - pass is loaded from pass_nfail_in on the exit edge; next state is DONE.
- DONE:
  - done=1; pass holds; test_mode=0.
  - start=1 → INIT. done and pass clear on that edge.
- Latency: done rises on the 2 + NUM_PATTERNS*(CHAIN_LENGTH+1) + CHAIN_LENGTH-th edge after the edge that samples start. Defaults give 3334 edges.
- Totals per run:
  - misr_enable high for exactly NUM_PATTERNS*CHAIN_LENGTH cycles.
  - scan_enable high for (NUM_PATTERNS+1)*CHAIN_LENGTH cycles.
- abort:
  - Takes priority over all transitions, including start in DONE.
  - Next state is IDLE; pass cleared; counters cleared.
  - lfsr untouched, since INIT reloads it.
- start while busy is ignored.
- reset asserted mid-run: all outputs drop to 0 immediately (asynchronously).
- Counter widths are $clog2 of their limit, minimum 1 bit. Counters never wrap within a legal run.

Test Plan:
- CHAIN_LENGTH=4, NUM_PATTERNS=3, start pulse:
  - misr_reset high exactly 1 cycle; done rises 21 edges after start.
  - scan_enable high 16 cycles; misr_enable high 12 cycles, none during the first 4 shift cycles.
- Default parameters, scan_in capture across the first 3 SHIFT cycles → bits 1, 0, 0, matching the LFSR model. Then a full run → done after 3334 edges.
- pass_nfail_in forced 1 during EVAL → pass=1 while done is high. Repeat with 0 → pass=0. A new start clears done and pass on the next edge.
- abort asserted in the 2nd pattern's SHIFT → next cycle state is IDLE and all outputs are 0. A following start rereplays an identical scan_in sequence from seed.
- reset pulled low mid-FLUSH (asynchronous, between edges) → all outputs 0 before the next edge. Release plus start → a full nominal run.
- start held high continuously → runs back-to-back; DONE is observed for exactly 1 cycle between runs; start pulses during busy are ignored.

Source files
------------

// File: rtl/bist_scan_controller.sv
// BIST scan sequencer: LFSR scan-in pattern generation, shift/capture sequencing,
// signature-compactor reset/enable control and a latched pass/fail verdict.
module bist_scan_controller #(
  parameter int unsigned CHAIN_LENGTH = 32,
  parameter int unsigned NUM_PATTERNS = 100,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic abort,
  input  logic pass_nfail_in,
  output logic scan_in,
  output logic scan_enable,
  output logic test_mode,
  output logic misr_reset,
  output logic misr_enable,
  output logic busy,
  output logic done,
  output logic pass
);

  localparam int unsigned BitW = (CHAIN_LENGTH > 1) ? $clog2(CHAIN_LENGTH) : 1;
  localparam int unsigned PatW = $clog2(NUM_PATTERNS + 1);
  localparam logic [BitW-1:0] BitLast = BitW'(CHAIN_LENGTH - 1);
  localparam logic [PatW-1:0] PatLast = PatW'(NUM_PATTERNS);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StShift,
    StCapture,
    StFlush,
    StEval,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic [PatW-1:0] pat_cnt_q, pat_cnt_d;
  logic            pass_q, pass_d;
  logic            lfsr_fb;

  logic scan_in_q, scan_enable_q, test_mode_q, misr_reset_q, misr_enable_q, done_q;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting toward bit 0
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    bit_cnt_d = bit_cnt_q;
    pat_cnt_d = pat_cnt_q;
    pass_d    = pass_q;
    // abort leaves the LFSR alone; INIT reloads it on the next run
    if (abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      pat_cnt_d = '0;
      pass_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) state_d = StInit;
        end
        StInit: begin
          lfsr_d    = LFSR_SEED;
          bit_cnt_d = '0;
          pat_cnt_d = '0;
          state_d   = StShift;
        end
        StShift: begin
          lfsr_d = {lfsr_fb, lfsr_q[15:1]};
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
            state_d   = StCapture;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        StCapture: begin
          pat_cnt_d = pat_cnt_q + 1'b1;
          state_d   = (pat_cnt_d == PatLast) ? StFlush : StShift;
        end
        StFlush: begin
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
            state_d   = StEval;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        StEval: begin
          pass_d  = pass_nfail_in;
          state_d = StDone;
        end
        StDone: begin
          if (start) begin
            pass_d  = 1'b0;
            state_d = StInit;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      lfsr_q        <= LFSR_SEED;
      bit_cnt_q     <= '0;
      pat_cnt_q     <= '0;
      pass_q        <= 1'b0;
      scan_in_q     <= 1'b0;
      scan_enable_q <= 1'b0;
      test_mode_q   <= 1'b0;
      misr_reset_q  <= 1'b0;
      misr_enable_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      bit_cnt_q     <= bit_cnt_d;
      pat_cnt_q     <= pat_cnt_d;
      pass_q        <= pass_d;
      scan_in_q     <= (state_d == StShift) && lfsr_d[0];
      scan_enable_q <= (state_d == StShift) || (state_d == StFlush);
      test_mode_q   <= (state_d != StIdle) && (state_d != StDone);
      misr_reset_q  <= (state_d == StInit);
      // pattern 0 unloads nothing meaningful, so the compactor skips it
      misr_enable_q <= ((state_d == StShift) && (pat_cnt_d != '0)) || (state_d == StFlush);
      done_q        <= (state_d == StDone);
    end
  end

  assign scan_in     = scan_in_q;
  assign scan_enable = scan_enable_q;
  assign test_mode   = test_mode_q;
  assign busy        = test_mode_q;
  assign misr_reset  = misr_reset_q;
  assign misr_enable = misr_enable_q;
  assign done        = done_q;
  assign pass        = pass_q;

endmodule

// File: tb/tb_bist_scan_controller.sv
// Scoreboard bench for bist_scan_controller: a small (4x3) and a default (32x100)
// instance checked against a run-timeline reference model.
module tb_bist_scan_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0] reset_v = 2'b11;
  logic [1:0] start_v = 2'b00;
  logic [1:0] abort_v = 2'b00;
  logic [1:0] pnf_v   = 2'b00;
  logic [1:0] scan_in_v, scan_enable_v, test_mode_v, misr_reset_v;
  logic [1:0] misr_enable_v, busy_v, done_v, pass_v;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int pnf_mode = 0;

  always @(posedge clock) edge_n <= edge_n + 1;

  always @(negedge clock) begin
    case (pnf_mode)
      1:       pnf_v = 2'b11;
      2:       pnf_v = 2'b00;
      default: pnf_v = 2'($urandom);
    endcase
  end

  task automatic check(input int inst, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL u%0d %s: got %0d expected %0d at %0t", inst, name, act, exp, $time);
    end
  endtask

  // Next LFSR value from the tap set {0,2,3,5} as a parity mask.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & 16'h002D), s[15:1]};
  endfunction

  function automatic logic [7:0] outs(input int i);
    return {scan_in_v[i], scan_enable_v[i], misr_reset_v[i], misr_enable_v[i],
            test_mode_v[i], busy_v[i], done_v[i], pass_v[i]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CL  = (g == 0) ? 4 : 32;
    localparam int NP  = (g == 0) ? 3 : 100;
    localparam int LAT = 2 + NP * (CL + 1) + CL;

    bist_scan_controller #(
      .CHAIN_LENGTH (CL),
      .NUM_PATTERNS (NP),
      .LFSR_SEED    (16'hACE1)
    ) u_dut (
      .clock         (clock),
      .reset         (reset_v[g]),
      .start         (start_v[g]),
      .abort         (abort_v[g]),
      .pass_nfail_in (pnf_v[g]),
      .scan_in       (scan_in_v[g]),
      .scan_enable   (scan_enable_v[g]),
      .test_mode     (test_mode_v[g]),
      .misr_reset    (misr_reset_v[g]),
      .misr_enable   (misr_enable_v[g]),
      .busy          (busy_v[g]),
      .done          (done_v[g]),
      .pass          (pass_v[g])
    );

    // Reference model: a run is a fixed timeline of LAT edges from the start edge.
    bit          run = 1'b0;
    bit          fin = 1'b0;
    bit          exp_pass = 1'b0;
    int          start_e = 0;
    logic [15:0] s;
    bit          exp_scan[$];
    int          exp_start[$];

    always @(posedge clock or negedge reset_v[g]) begin
      if (!reset_v[g]) begin
        run = 1'b0; fin = 1'b0; exp_pass = 1'b0;
        exp_scan.delete(); exp_start.delete();
      end else if (abort_v[g] && (run || fin)) begin
        run = 1'b0; fin = 1'b0; exp_pass = 1'b0;
        exp_scan.delete(); exp_start.delete();
      end else if (run) begin
        if (edge_n - start_e == LAT) begin
          run = 1'b0; fin = 1'b1; exp_pass = pnf_v[g];
        end
      end else if (start_v[g]) begin
        run = 1'b1; fin = 1'b0; exp_pass = 1'b0; start_e = edge_n;
        s = 16'hACE1;
        for (int i = 0; i < NP * CL; i++) begin
          exp_scan.push_back(s[0]);
          s = lfsr_next(s);
        end
        for (int i = 0; i < CL; i++) exp_scan.push_back(1'b0);
        exp_start.push_back(start_e);
      end
    end

    // Monitor: pops expected scan bits on every shift cycle and run records on done.
    bit prev_done = 1'b0;
    int se_cnt = 0, me_cnt = 0, mr_cnt = 0, early_cnt = 0;

    always @(negedge clock) begin
      if (!reset_v[g]) begin
        check(g, "reset_outs", int'(outs(g)), 0);
        se_cnt = 0; me_cnt = 0; mr_cnt = 0; early_cnt = 0;
      end else begin
        check(g, "busy_eq_test_mode", busy_v[g], test_mode_v[g]);
        check(g, "test_mode", test_mode_v[g], run);
        check(g, "done", done_v[g], fin);
        check(g, "pass", pass_v[g], fin && exp_pass);
        if (!run) check(g, "idle_strobes", int'(outs(g) >> 4), 0);
        if (scan_enable_v[g]) begin
          if (exp_scan.size() == 0) check(g, "scan_extra", 1, 0);
          else check(g, "scan_in", scan_in_v[g], exp_scan.pop_front());
          if (misr_enable_v[g] && se_cnt < CL) early_cnt++;
          se_cnt++;
        end else begin
          check(g, "noshift_strobes", int'({scan_in_v[g], misr_enable_v[g]}), 0);
        end
        if (misr_enable_v[g]) me_cnt++;
        if (misr_reset_v[g]) mr_cnt++;
        if (done_v[g] && !prev_done) begin
          if (exp_start.size() == 0) check(g, "done_unexpected", 1, 0);
          else check(g, "latency", edge_n - 1 - exp_start.pop_front(), LAT);
          check(g, "scan_enable_total", se_cnt, (NP + 1) * CL);
          check(g, "misr_enable_total", me_cnt, NP * CL);
          check(g, "misr_reset_total", mr_cnt, 1);
          check(g, "misr_en_pattern0", early_cnt, 0);
          check(g, "scan_left", exp_scan.size(), 0);
          se_cnt = 0; me_cnt = 0; mr_cnt = 0; early_cnt = 0;
        end
        if (!run && !fin) begin
          se_cnt = 0; me_cnt = 0; mr_cnt = 0; early_cnt = 0;
        end
      end
      prev_done = done_v[g];
    end
  end

  task automatic pulse_start(input int i);
    @(negedge clock) start_v[i] = 1'b1;
    @(negedge clock) start_v[i] = 1'b0;
  endtask

  task automatic run_until_done(input int i, input int budget, input bit noise, output int n);
    n = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clock);
      if (done_v[i]) begin
        start_v[i] = 1'b0;
        n = c;
        break;
      end
      if (noise) start_v[i] = busy_v[i] && ($urandom_range(0, 3) == 0);
    end
    start_v[i] = 1'b0;
    if (n == 0) check(i, "done_timeout", 0, 1);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int k;
    int done_cycles;
    int exp_bits[3];
    exp_bits = '{1, 0, 0};

    #1 reset_v = 2'b00;
    repeat (3) @(negedge clock);
    check(0, "reset_state", int'(outs(0)), 0);
    check(1, "reset_state", int'(outs(1)), 0);
    reset_v = 2'b11;
    repeat (2) @(negedge clock);

    // Nominal small run, verdict forced to 1 at EVAL, noise on start while busy.
    pnf_mode = 1;
    pulse_start(0);
    run_until_done(0, 100, 1'b1, n);
    check(0, "latency_small", n, 21);
    check(0, "pass_high", pass_v[0], 1);
    repeat (3) @(negedge clock);
    check(0, "pass_hold", int'({done_v[0], pass_v[0]}), 3);

    // New start clears done and pass on the next edge; verdict 0 this time.
    pnf_mode = 2;
    pulse_start(0);
    check(0, "start_clears", int'({done_v[0], pass_v[0]}), 0);
    run_until_done(0, 100, 1'b1, n);
    check(0, "pass_low", int'({done_v[0], pass_v[0]}), 2);
    pnf_mode = 0;

    // Abort during the second pattern's shift, then replay from seed.
    pulse_start(0);
    k = 4 + 2 + int'($urandom_range(0, 3));
    repeat (k) @(negedge clock);
    check(0, "pat2_misr_en", misr_enable_v[0], 1);
    abort_v[0] = 1'b1;
    @(negedge clock) abort_v[0] = 1'b0;
    check(0, "abort_outs", int'(outs(0)), 0);
    repeat (2) @(negedge clock);
    pulse_start(0);
    run_until_done(0, 100, 1'b1, n);

    // Asynchronous reset mid-FLUSH, then a nominal run.
    pulse_start(0);
    k = 16 + int'($urandom_range(0, 3));
    repeat (k) @(negedge clock);
    check(0, "in_flush", int'({scan_in_v[0], scan_enable_v[0], misr_enable_v[0]}), 3);
    #2 reset_v[0] = 1'b0;
    #1 check(0, "async_reset_outs", int'(outs(0)), 0);
    @(negedge clock) reset_v[0] = 1'b1;
    pulse_start(0);
    run_until_done(0, 100, 1'b0, n);
    check(0, "after_reset_latency", n, 21);

    // start held high: back-to-back runs with a single DONE cycle between.
    @(negedge clock) start_v[0] = 1'b1;
    done_cycles = 0;
    repeat (50) begin
      @(negedge clock);
      if (done_v[0]) done_cycles++;
    end
    start_v[0] = 1'b0;
    check(0, "held_start_done_cycles", done_cycles, 2);
    run_until_done(0, 100, 1'b0, n);

    // Default parameters: first scan bits from seed, then full-run latency.
    pulse_start(1);
    for (int b = 0; b < 3; b++) begin
      @(negedge clock);
      check(1, "first_scan_bits", scan_in_v[1], exp_bits[b]);
    end
    run_until_done(1, 4000, 1'b1, n);
    check(1, "default_latency", 3 + n, 3334);

    repeat (5) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
